// File: rtl/cpx2real_pkg.sv
// Shared widths, quarter-wave sine table and quadrant mapping for cpx2real.
package cpx2real_pkg;

  localparam int IN_W   = 13;
  localparam int OUT_W  = 12;
  localparam int TRIG_W = 12;
  localparam int PROD_W = 25;
  localparam int SUM_W  = 26;
  localparam int RND_SH = 11;

  // L[k] = round(2047*sin(pi/2*(k+0.5)/16)); half-bin offset keeps the table symmetric
  localparam logic [10:0] SIN_TBL [16] = '{
    11'd100,  11'd300,  11'd497,  11'd690,
    11'd875,  11'd1052, 11'd1219, 11'd1375,
    11'd1517, 11'd1644, 11'd1756, 11'd1850,
    11'd1927, 11'd1986, 11'd2025, 11'd2045
  };

  function automatic logic [TRIG_W-1:0] quad_sin(input logic [1:0] q, input logic [3:0] i);
    logic [TRIG_W-1:0] r;
    case (q)
      2'd0:    r = {1'b0, SIN_TBL[i]};
      2'd1:    r = {1'b0, SIN_TBL[4'd15 - i]};
      2'd2:    r = 12'd0 - {1'b0, SIN_TBL[i]};
      2'd3:    r = 12'd0 - {1'b0, SIN_TBL[4'd15 - i]};
      default: r = 12'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpx2real_nco.sv
// Phase accumulator with per-sample phase tagging and registered sin/cos lookup.
module cpx2real_nco
  import cpx2real_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_rdy,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] phase_inc,
  output logic [TRIG_W-1:0]  sin_v,
  output logic [TRIG_W-1:0]  cos_v
);

  localparam int TAG_W = LUT_AW + 2;

  logic [PHASE_W-1:0] ph;
  logic [TAG_W-1:0]   tag;
  logic [TAG_W-1:0]   cos_tag;

  // Only quadrant and table index travel with the sample; cos is a quarter turn ahead.
  always_comb begin
    cos_tag = tag + {2'b01, {LUT_AW{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ph    <= '0;
      tag   <= '0;
      sin_v <= '0;
      cos_v <= '0;
    end else begin
      if (data_rdy) begin
        if (phase_clr) begin
          tag <= '0;
          ph  <= phase_inc;
        end else begin
          tag <= ph[PHASE_W-1 -: TAG_W];
          ph  <= ph + phase_inc;
        end
      end else if (phase_clr) begin
        ph <= '0;
      end
      sin_v <= quad_sin(tag[TAG_W-1 -: 2], tag[LUT_AW-1:0]);
      cos_v <= quad_sin(cos_tag[TAG_W-1 -: 2], cos_tag[LUT_AW-1:0]);
    end
  end

endmodule

// File: rtl/cpx2real.sv
// Complex-to-real upconverter: x = re*cos - im*sin, rounded to 12 bits.
// Define CPX2REAL_SAT_EN to saturate the output instead of wrapping.
module cpx2real
  import cpx2real_pkg::*;
#(
  parameter int PHASE_W = 16,
  parameter int LUT_AW  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_rdy,
  input  logic [IN_W-1:0]    re,
  input  logic [IN_W-1:0]    im,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               phase_clr,
  output logic [OUT_W-1:0]   x_tx,
  output logic               x_rdy
);

  logic [TRIG_W-1:0] sin_v, cos_v;
  logic [IN_W-1:0]   re1, im1, re2, im2;
  logic [PROD_W-1:0] prod_c, prod_s;
  logic              v1, v2, v3;
  logic [SUM_W-1:0]  sum;
  logic [OUT_W-1:0]  y_lim;
  logic              unused_bits;

  cpx2real_nco #(.PHASE_W(PHASE_W), .LUT_AW(LUT_AW)) u_nco (
    .clk       (clk),
    .reset     (reset),
    .data_rdy  (data_rdy),
    .phase_clr (phase_clr),
    .phase_inc (phase_inc),
    .sin_v     (sin_v),
    .cos_v     (cos_v)
  );

  // (d + 1024) >>> 11 equals the upper bits plus bit 10, so d[9:0] never matters.
`ifdef CPX2REAL_SAT_EN
  logic [SUM_W-RND_SH-1:0] y_full;
  always_comb begin
    y_full      = sum[SUM_W-1:RND_SH] + {{(SUM_W-RND_SH-1){1'b0}}, sum[RND_SH-1]};
    unused_bits = ^sum[RND_SH-2:0];
    if ((y_full[14:11] == 4'b0000) || (y_full[14:11] == 4'b1111)) begin
      y_lim = y_full[OUT_W-1:0];
    end else if (y_full[14]) begin
      y_lim = 12'h800;
    end else begin
      y_lim = 12'h7FF;
    end
  end
`else
  always_comb begin
    y_lim       = sum[RND_SH+OUT_W-1:RND_SH] + {{(OUT_W-1){1'b0}}, sum[RND_SH-1]};
    unused_bits = ^{sum[SUM_W-1:RND_SH+OUT_W], sum[RND_SH-2:0]};
  end
`endif

  always_comb begin
    sum = {prod_c[PROD_W-1], prod_c} - {prod_s[PROD_W-1], prod_s};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      re1    <= '0;
      im1    <= '0;
      re2    <= '0;
      im2    <= '0;
      prod_c <= '0;
      prod_s <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      x_tx   <= '0;
      x_rdy  <= 1'b0;
    end else begin
      re1    <= re;
      im1    <= im;
      v1     <= data_rdy;
      re2    <= re1;
      im2    <= im1;
      v2     <= v1;
      prod_c <= PROD_W'($signed(re2) * $signed(cos_v));
      prod_s <= PROD_W'($signed(im2) * $signed(sin_v));
      v3     <= v2;
      x_rdy  <= v3;
      if (v3) begin
        x_tx <= y_lim;
      end
    end
  end

endmodule

// File: tb/tb_cpx2real.sv
// Directed self-checking bench for cpx2real (honours CPX2REAL_SAT_EN).
module tb_cpx2real;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_rdy = 1'b0;
  logic [12:0] re = '0;
  logic [12:0] im = '0;
  logic [15:0] phase_inc = '0;
  logic        phase_clr = 1'b0;
  logic [11:0] x_tx;
  logic        x_rdy;

  int tests = 0;
  int fails = 0;

  logic [12:0] s_re [8];
  logic [12:0] s_im [8];
  logic        s_clr [8];
  logic        cap_rdy [16];
  logic [11:0] cap_x [16];

  cpx2real dut (
    .clk       (clk),
    .reset     (reset),
    .data_rdy  (data_rdy),
    .re        (re),
    .im        (im),
    .phase_inc (phase_inc),
    .phase_clr (phase_clr),
    .x_tx      (x_tx),
    .x_rdy     (x_rdy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1; data_rdy = 1'b0; phase_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives n consecutive samples from negedge; cap[c] holds outputs after posedge c.
  task automatic stream(input int n);
    for (int c = 0; c < n + 8; c++) begin
      if (c < n) begin
        data_rdy = 1'b1; re = s_re[c]; im = s_im[c]; phase_clr = s_clr[c];
      end else begin
        data_rdy = 1'b0; re = '0; im = '0; phase_clr = 1'b0;
      end
      @(negedge clk);
      cap_rdy[c+1] = x_rdy;
      cap_x[c+1]   = x_tx;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (x_tx !== 12'd0) begin fails++; $display("FAIL reset_x got %0d exp 0", x_tx); end
    tests++; if (x_rdy !== 1'b0) begin fails++; $display("FAIL reset_rdy got %0b exp 0", x_rdy); end
  endtask

  task automatic test_single();
    phase_inc = 16'h0000;
    s_re[0] = 13'd1000; s_im[0] = 13'd0; s_clr[0] = 1'b0;
    stream(1);
    for (int c = 1; c <= 8; c++) begin
      tests++;
      if (cap_rdy[c] !== (c == 4)) begin
        fails++; $display("FAIL single_rdy c=%0d got %0b exp %0b", c, cap_rdy[c], (c == 4));
      end
    end
    tests++; if (cap_x[4] !== 12'd999) begin fails++; $display("FAIL single_x got %0d exp 999", $signed(cap_x[4])); end
    tests++; if (cap_x[8] !== 12'd999) begin fails++; $display("FAIL single_hold got %0d exp 999", $signed(cap_x[8])); end
  endtask

  task automatic test_imag();
    phase_inc = 16'h0000;
    s_re[0] = 13'd0; s_im[0] = 13'd1000; s_clr[0] = 1'b0;
    stream(1);
    tests++; if (cap_rdy[4] !== 1'b1) begin fails++; $display("FAIL imag_rdy got %0b exp 1", cap_rdy[4]); end
    tests++; if (cap_x[4] !== 12'hFCF) begin fails++; $display("FAIL imag_x got %0d exp -49", $signed(cap_x[4])); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_v [4];
    exp_v = '{12'd999, 12'hFCF, 12'hC19, 12'd49};
    do_reset();
    phase_inc = 16'h4000;
    for (int j = 0; j < 4; j++) begin
      s_re[j] = 13'd1000; s_im[j] = 13'd0; s_clr[j] = 1'b0;
    end
    stream(4);
    tests++; if (cap_rdy[3] !== 1'b0) begin fails++; $display("FAIL b2b_early got %0b exp 0", cap_rdy[3]); end
    tests++; if (cap_rdy[8] !== 1'b0) begin fails++; $display("FAIL b2b_late got %0b exp 0", cap_rdy[8]); end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (cap_rdy[j+4] !== 1'b1 || cap_x[j+4] !== exp_v[j]) begin
        fails++; $display("FAIL b2b_x j=%0d got %0d/%0b exp %0d/1", j, $signed(cap_x[j+4]), cap_rdy[j+4], $signed(exp_v[j]));
      end
    end
  endtask

  task automatic test_limit();
    logic [11:0] exp_x;
`ifdef CPX2REAL_SAT_EN
    exp_x = 12'd2047;
`else
    exp_x = 12'd193;
`endif
    do_reset();
    phase_inc = 16'h0000;
    s_re[0] = 13'd4095; s_im[0] = 13'h1000; s_clr[0] = 1'b0;
    stream(1);
    tests++;
    if (cap_rdy[4] !== 1'b1 || cap_x[4] !== exp_x) begin
      fails++; $display("FAIL limit_x got %0d/%0b exp %0d/1", $signed(cap_x[4]), cap_rdy[4], $signed(exp_x));
    end
  endtask

  task automatic test_phase_clr();
    logic [11:0] exp_v [4];
    exp_v = '{12'd999, 12'hFCF, 12'd999, 12'hFCF};
    do_reset();
    phase_inc = 16'h4000;
    for (int j = 0; j < 4; j++) begin
      s_re[j] = 13'd1000; s_im[j] = 13'd0; s_clr[j] = (j == 2);
    end
    stream(4);
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (cap_rdy[j+4] !== 1'b1 || cap_x[j+4] !== exp_v[j]) begin
        fails++; $display("FAIL clr_x j=%0d got %0d/%0b exp %0d/1", j, $signed(cap_x[j+4]), cap_rdy[j+4], $signed(exp_v[j]));
      end
    end
  endtask

  task automatic test_reset_flight();
    int seen;
    phase_inc = 16'h4000;
    for (int j = 0; j < 3; j++) begin
      data_rdy = 1'b1; re = 13'd1000; im = 13'd0; phase_clr = 1'b0;
      @(negedge clk);
    end
    data_rdy = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (x_rdy !== 1'b0) seen++;
      @(negedge clk);
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL flight_rdy got %0d strobes exp 0", seen); end
    tests++; if (x_tx !== 12'd0) begin fails++; $display("FAIL flight_x got %0d exp 0", $signed(x_tx)); end
    s_re[0] = 13'd1000; s_im[0] = 13'd0; s_clr[0] = 1'b0;
    stream(1);
    tests++;
    if (cap_rdy[4] !== 1'b1 || cap_x[4] !== 12'd999) begin
      fails++; $display("FAIL flight_phase got %0d/%0b exp 999/1", $signed(cap_x[4]), cap_rdy[4]);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_imag();
    test_back_to_back();
    test_limit();
    test_phase_clr();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpx2real.md
# cpx2real

Transmit-side complex-to-real upconverter for the acoustic modem datapath. It accepts complex baseband samples (13-bit `re`/`im`, the same format the receive-side Hilbert stage produces) and mixes them with a quadrature carrier from an internal NCO. It outputs the real passband sample `x_tx = re·cos(φ) − im·sin(φ)`, rounded and limited to the 12-bit transducer DAC word. The block sits between the baseband modulator and the DAC interface.

## Interface
Parameters:
- `PHASE_W`, 16, phase accumulator width (bits)
- `LUT_AW`, 4, quarter-wave sine table address width (16 entries)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `data_rdy`  in  1  input strobe; `re`/`im` are valid this cycle
- `re`  in  13  signed real part, integer
- `im`  in  13  signed imaginary part, integer
- `phase_inc`  in  PHASE_W  unsigned NCO increment per accepted sample (f = phase_inc·fs/2^PHASE_W)
- `phase_clr`  in  1  clears NCO phase to 0
- `x_tx`  out  12  signed real output sample, integer
- `x_rdy`  out  1  `x_tx` valid strobe

## Operation
- No backpressure. `data_rdy` may be high every cycle. The pipeline always advances, and a valid bit travels with each sample.
- NCO: the phase accumulator `ph` only updates on an accepted sample. On `data_rdy`, the sample is tagged with the current `ph` and then `ph <= ph + phase_inc` (mod 2^PHASE_W).
- `phase_clr` without `data_rdy`: `ph <= 0`.
- `phase_clr` with `data_rdy` in the same cycle: the sample uses phase 0 and `ph <= phase_inc`.
- LUT: `L[k] = round(2047·sin(π/2·(k+0.5)/16))`, k=0..15, unsigned 11-bit. Endpoints: L[0]=100, L[15]=2045.
- Table lookup uses `q = ph[15:14]` and `i = ph[13:10]`:
  - sin: q0 → L[i]; q1 → L[15−i]; q2 → −L[i]; q3 → −L[15−i]
  - cos(ph) = sin(ph + 0x4000)
  - sin and cos are 12-bit signed.
- Arithmetic:
  - Products `re·cos` and `im·sin`: 25-bit signed each.
  - `d = re·cos − im·sin`: 26-bit signed; this cannot overflow.
  - `y = (d + 1024) >>> 11`: arithmetic shift, round-half-up.
  - `y` is then limited to 12 bits; see Configuration.

## Timing
- Pipeline stages:
  - S1: register `re`, `im` and the tagged phase.
  - S2: register sin and cos.
  - S3: register both products.
  - S4: register `x_tx` and assert `x_rdy`.
- Latency: `x_rdy` goes high exactly 4 cycles after the `data_rdy` cycle, for 1 cycle per sample.
- Back-to-back samples produce back-to-back outputs. Order is preserved.
- `x_tx` holds its last value while `x_rdy` is low.
- Reset values: `x_tx` = 0, `x_rdy` = 0, `ph` = 0, all pipeline registers and valid bits = 0.
- Reset mid-operation: all in-flight samples are discarded. No `x_rdy` may appear for any sample accepted before reset.
- `phase_inc` changes take effect on the next accepted sample. The tag of the current sample is not affected.

## Configuration
- `CPX2REAL_SAT_EN` defined: `y` saturates to the range [−2048, 2047].
- `CPX2REAL_SAT_EN` undefined: `x_tx = y[11:0]`, which wraps. Saturation logic is absent.

## Structure
- `cpx2real_pkg` holds:
  - the width constants (input 13, output 12, product 25, sum 26, rounding shift 11);
  - the 16-entry `L[]` constant table;
  - the quadrant-mapping function.
- Sub-module `cpx2real_nco` contains the phase accumulator, `phase_clr` handling and the sin/cos lookup. It covers S1–S2 phase handling and outputs sin/cos registered.
- The top level contains the multipliers, subtract, round, limit and valid pipeline.

## Test plan
- Reset, then `phase_inc`=0, `re`=1000, `im`=0, one strobe → exactly 4 cycles later `x_tx`=999 and `x_rdy`=1 for one cycle.
- `phase_inc`=0, `re`=0, `im`=1000 → `x_tx`=−49.
- `phase_inc`=0x4000, `re`=1000, `im`=0, strobe on 4 consecutive cycles → outputs 999, −49, −999, 49 on 4 consecutive cycles.
- `re`=4095, `im`=−4096, phase 0 → `x_tx`=2047 with `CPX2REAL_SAT_EN` defined; `x_tx`=193 without it.
- Stream with `phase_inc`=0x4000, then assert `phase_clr` together with `data_rdy` on the 3rd sample (`re`=1000, `im`=0) → that output is 999 and the next output is −49.
- Assert `reset` with 3 samples in flight → no `x_rdy` afterwards, `x_tx`=0, and the next sample uses phase 0.
